// File: rtl/operand_inject_scheduler.sv
// operand_inject_scheduler: buffers E-node results carrying up to two targets
// and serialises them into single-flit req/ack transfers on the local port of
// the operand network, target 0 before target 1.
// Operand packing: {valid, source_instr[INSTR_W-1:0], data[DATA_W-1:0]}.
//
// state | meaning
// IDLE  | nothing presented; loads the FIFO head as soon as one exists
// SEND0 | presenting the head entry's target 0
// SEND1 | presenting the head entry's target 1 (or its only target)
module operand_inject_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int DATA_W     = 32,
  parameter int INSTR_W    = 7,
  localparam int OP_W      = DATA_W + 1 + INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [OP_W-1:0]    res_operand,
  input  logic               t0_valid,
  input  logic [INSTR_W-1:0] t0_instr,
  input  logic [1:0]         t0_slot,
  input  logic               t1_valid,
  input  logic [INSTR_W-1:0] t1_instr,
  input  logic [1:0]         t1_slot,
  output logic [OP_W-1:0]    net_operand,
  output logic [INSTR_W-1:0] net_dest_instr,
  output logic [1:0]         net_dest_slot,
  output logic               net_req,
  input  logic               net_ack,
  output logic               busy,
  output logic [CNT_W-1:0]   sent_count,
  output logic [CNT_W-1:0]   stall_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;

  state_t state;

  logic [OP_W-1:0]    fifo_op   [FIFO_DEPTH];
  logic [1:0]         fifo_mask [FIFO_DEPTH];
  logic [INSTR_W-1:0] fifo_i0   [FIFO_DEPTH];
  logic [1:0]         fifo_s0   [FIFO_DEPTH];
  logic [INSTR_W-1:0] fifo_i1   [FIFO_DEPTH];
  logic [1:0]         fifo_s1   [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] nxt_ptr;
  logic [PTR_W-1:0] src_ptr;
  logic [PTR_W:0]   occ;

  logic eff0;
  logic eff1;
  logic push;
  logic pop;
  logic xfer;
  logic more;
  logic load_src;

  // slot 3 is reserved, so such a target is simply not emitted
  assign eff0 = t0_valid && (t0_slot != 2'd3);
  assign eff1 = t1_valid && (t1_slot != 2'd3);

  assign res_ready = occ < (PTR_W+1)'(FIFO_DEPTH);
  assign push      = res_valid && res_ready && !flush && (eff0 || eff1);
  assign xfer      = net_req && net_ack;
  assign more      = occ > (PTR_W+1)'(1);
  assign nxt_ptr   = rd_ptr + PTR_W'(1);
  assign src_ptr   = (state == IDLE) ? rd_ptr : nxt_ptr;
  assign busy      = (occ != '0) || net_req;

  // head leaves the FIFO when its last effective target is accepted
  always_comb begin
    pop = 1'b0;
    if (xfer) begin
      pop = (state == SEND1) || !fifo_mask[rd_ptr][1];
    end
  end

  // a new entry is presented from IDLE, or back-to-back after a pop when another is queued
  assign load_src = ((state == IDLE) && (occ != '0)) || (pop && more);

  // result storage; contents need no reset since occupancy qualifies every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]   <= res_operand;
      fifo_mask[wr_ptr] <= {eff1, eff0};
      fifo_i0[wr_ptr]   <= t0_instr;
      fifo_s0[wr_ptr]   <= t0_slot;
      fifo_i1[wr_ptr]   <= t1_instr;
      fifo_s1[wr_ptr]   <= t1_slot;
    end
  end

  // FIFO pointers and occupancy; flush discards everything buffered
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= nxt_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // injection FSM with registered network outputs and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      net_req        <= 1'b0;
      net_operand    <= '0;
      net_dest_instr <= '0;
      net_dest_slot  <= '0;
      sent_count     <= '0;
      stall_count    <= '0;
    end else begin
      if (xfer && !flush && (sent_count != CNT_MAX)) begin
        sent_count <= sent_count + CNT_W'(1);
      end
      if (net_req && !net_ack && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (flush) begin
        state   <= IDLE;
        net_req <= 1'b0;
      end else if (load_src) begin
        net_req     <= 1'b1;
        net_operand <= fifo_op[src_ptr];
        if (fifo_mask[src_ptr][0]) begin
          state          <= SEND0;
          net_dest_instr <= fifo_i0[src_ptr];
          net_dest_slot  <= fifo_s0[src_ptr];
        end else begin
          state          <= SEND1;
          net_dest_instr <= fifo_i1[src_ptr];
          net_dest_slot  <= fifo_s1[src_ptr];
        end
      end else if (xfer) begin
        if (!pop) begin
          state          <= SEND1;
          net_dest_instr <= fifo_i1[rd_ptr];
          net_dest_slot  <= fifo_s1[rd_ptr];
        end else begin
          state   <= IDLE;
          net_req <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_inject_scheduler.sv
// Bench for operand_inject_scheduler: directed table, hand-written corner
// sequences, then random traffic against a flit-queue reference model.
`timescale 1ns/1ps
module tb_operand_inject_scheduler;

  localparam int DEPTH = 4;
  localparam int CW    = 6;
  localparam int DW    = 32;
  localparam int IW    = 7;
  localparam int OW    = DW + 1 + IW;
  localparam int CMAX  = (1 << CW) - 1;
  localparam logic [OW-1:0] OPC = {1'b1, 7'd3, 32'h0000_1234};

  logic          clk = 1'b0;
  logic          rst, flush, res_valid, t0_valid, t1_valid, net_ack;
  logic [OW-1:0] res_operand;
  logic [IW-1:0] t0_instr, t1_instr;
  logic [1:0]    t0_slot, t1_slot;
  logic          res_ready, net_req, busy;
  logic [OW-1:0] net_operand;
  logic [IW-1:0] net_dest_instr;
  logic [1:0]    net_dest_slot;
  logic [CW-1:0] sent_count, stall_count;

  always #5 clk = ~clk;

  operand_inject_scheduler #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .res_operand(res_operand),
    .t0_valid(t0_valid), .t0_instr(t0_instr), .t0_slot(t0_slot),
    .t1_valid(t1_valid), .t1_instr(t1_instr), .t1_slot(t1_slot),
    .net_operand(net_operand), .net_dest_instr(net_dest_instr),
    .net_dest_slot(net_dest_slot), .net_req(net_req), .net_ack(net_ack),
    .busy(busy), .sent_count(sent_count), .stall_count(stall_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: queue of buffered results, each a compact list of its flits
  typedef struct {
    logic [OW-1:0] op;
    int            nf;
    int            pos;
    logic [IW-1:0] i0, i1;
    logic [1:0]    s0, s1;
  } ent_t;

  ent_t mq[$];
  bit   m_req   = 1'b0;
  int   m_sent  = 0;
  int   m_stall = 0;
  bit   m_acc   = 1'b0;

  task automatic model_edge();
    ent_t e;
    m_acc = 1'b0;
    if (rst) begin
      mq.delete();
      m_req = 1'b0; m_sent = 0; m_stall = 0;
      return;
    end
    if (m_req && !net_ack && m_stall < CMAX) m_stall++;
    if (flush) begin
      mq.delete();
      m_req = 1'b0;
      return;
    end
    m_acc = res_valid && (mq.size() < DEPTH);
    if (m_req && net_ack) begin
      if (m_sent < CMAX) m_sent++;
      e = mq[0];
      e.pos++;
      mq[0] = e;
      if (e.pos == e.nf) begin
        mq.delete(0);
        m_req = (mq.size() != 0);
      end
    end else if (!m_req) begin
      m_req = (mq.size() != 0);
    end
    if (m_acc) begin
      e = '{op: res_operand, nf: 0, pos: 0, i0: '0, i1: '0, s0: '0, s1: '0};
      if (t0_valid && t0_slot != 2'd3) begin
        e.i0 = t0_instr; e.s0 = t0_slot; e.nf = 1;
      end
      if (t1_valid && t1_slot != 2'd3) begin
        if (e.nf == 0) begin e.i0 = t1_instr; e.s0 = t1_slot; end
        else begin e.i1 = t1_instr; e.s1 = t1_slot; end
        e.nf++;
      end
      if (e.nf > 0) mq.push_back(e);
    end
  endtask

  task automatic check_model();
    chk("m_net_req", net_req, m_req);
    chk("m_res_ready", res_ready, mq.size() < DEPTH);
    chk("m_busy", busy, (mq.size() != 0) || m_req);
    chk("m_sent_count", sent_count, m_sent);
    chk("m_stall_count", stall_count, m_stall);
    if (m_req && mq.size() != 0) begin
      chk("m_net_operand", net_operand, mq[0].op);
      chk("m_net_dest_instr", net_dest_instr, (mq[0].pos == 0) ? mq[0].i0 : mq[0].i1);
      chk("m_net_dest_slot", net_dest_slot, (mq[0].pos == 0) ? mq[0].s0 : mq[0].s1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_in(input bit r, input bit f, input bit rv,
                        input bit a0v, input logic [IW-1:0] a0i, input logic [1:0] a0s,
                        input bit a1v, input logic [IW-1:0] a1i, input logic [1:0] a1s,
                        input bit ack);
    rst = r; flush = f; res_valid = rv;
    t0_valid = a0v; t0_instr = a0i; t0_slot = a0s;
    t1_valid = a1v; t1_instr = a1i; t1_slot = a1s;
    net_ack = ack;
  endtask

  typedef struct {
    bit            r, f, rv, a0v, a1v, ack;
    logic [IW-1:0] a0i, a1i;
    logic [1:0]    a0s, a1s;
    bit            req, rdy, bsy;
    logic [IW-1:0] ei;
    logic [1:0]    es;
    int            sent, stall;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit f, input bit rv,
                              input bit a0v, input int a0i, input int a0s,
                              input bit a1v, input int a1i, input int a1s, input bit ack,
                              input bit req, input int ei, input int es,
                              input bit rdy, input bit bsy, input int sent, input int stall);
    vec_t v;
    v.r = r; v.f = f; v.rv = rv; v.ack = ack;
    v.a0v = a0v; v.a0i = IW'(a0i); v.a0s = 2'(a0s);
    v.a1v = a1v; v.a1i = IW'(a1i); v.a1s = 2'(a1s);
    v.req = req; v.ei = IW'(ei); v.es = 2'(es);
    v.rdy = rdy; v.bsy = bsy; v.sent = sent; v.stall = stall;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc24, saw24;
    int sent_before, ackp;

    //            r f rv t0v i s t1v i s ack | req i s rdy bsy sent stall
    tbl.push_back(mk(1,0,0, 0,0,0, 0,0,0, 0,   0,0,0, 1,0, 0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,   0,0,0, 1,0, 0,0));
    tbl.push_back(mk(0,0,1, 1,5,0, 1,9,2, 1,   0,0,0, 1,1, 0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 1,   1,5,0, 1,1, 0,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 1,   1,9,2, 1,1, 1,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 1,   0,0,0, 1,0, 2,0));
    tbl.push_back(mk(0,0,1, 1,5,0, 1,9,2, 0,   0,0,0, 1,1, 2,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,   1,5,0, 1,1, 2,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,   1,5,0, 1,1, 2,1));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,   1,5,0, 1,1, 2,2));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,   1,5,0, 1,1, 2,3));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 1,   1,9,2, 1,1, 3,3));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 1,   0,0,0, 1,0, 4,3));
    tbl.push_back(mk(0,0,1, 0,0,0, 1,4,3, 0,   0,0,0, 1,0, 4,3));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,   0,0,0, 1,0, 4,3));
    tbl.push_back(mk(0,0,1, 0,0,0, 1,12,1, 1,  0,0,0, 1,1, 4,3));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 1,   1,12,1, 1,1, 4,3));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 1,   0,0,0, 1,0, 5,3));
    tbl.push_back(mk(0,0,1, 1,3,3, 1,7,2, 1,   0,0,0, 1,1, 5,3));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 1,   1,7,2, 1,1, 5,3));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0,0, 1,   0,0,0, 1,0, 6,3));

    res_operand = OPC;
    set_in(0,0,0, 0,0,0, 0,0,0, 0);

    foreach (tbl[i]) begin
      set_in(tbl[i].r, tbl[i].f, tbl[i].rv, tbl[i].a0v, tbl[i].a0i, tbl[i].a0s,
             tbl[i].a1v, tbl[i].a1i, tbl[i].a1s, tbl[i].ack);
      step();
      chk($sformatf("tbl%0d_req", i), net_req, tbl[i].req);
      if (tbl[i].req) begin
        chk($sformatf("tbl%0d_instr", i), net_dest_instr, tbl[i].ei);
        chk($sformatf("tbl%0d_slot", i), net_dest_slot, tbl[i].es);
        chk($sformatf("tbl%0d_operand", i), net_operand, OPC);
      end
      chk($sformatf("tbl%0d_ready", i), res_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_sent", i), sent_count, tbl[i].sent);
      chk($sformatf("tbl%0d_stall", i), stall_count, tbl[i].stall);
    end

    // five single-target results against a stalled network
    for (int i = 0; i < 4; i++) begin
      set_in(0,0,1, 1,IW'(20+i),2'd1, 0,0,0, 0);
      step();
    end
    chk("tp3_full_ready", res_ready, 1'b0);
    set_in(0,0,1, 1,24,1, 0,0,0, 0);
    step();
    step();
    chk("tp3_held_ready", res_ready, 1'b0);
    acc24 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("tp3_order_req", net_req, 1'b1);
      chk("tp3_order_instr", net_dest_instr, 20 + j);
      set_in(0,0,!acc24, 1,24,1, 0,0,0, 1);
      step();
      if (m_acc) acc24 = 1'b1;
    end
    chk("tp3_fifth_accepted", acc24, 1'b1);
    saw24 = 1'b0;
    set_in(0,0,0, 0,0,0, 0,0,0, 1);
    for (int k = 0; k < 20 && (mq.size() != 0 || m_req); k++) begin
      if (net_req && net_dest_instr == 7'd24) saw24 = 1'b1;
      step();
    end
    chk("tp3_fifth_sent", saw24, 1'b1);
    chk("tp3_drained_busy", busy, 1'b0);

    // flush with two entries buffered and a flit stalled
    set_in(0,0,1, 1,40,0, 1,41,1, 0); step();
    set_in(0,0,1, 1,42,2, 0,0,0, 0);  step();
    set_in(0,0,0, 0,0,0, 0,0,0, 0);   step();
    chk("tp5_setup_req", net_req, 1'b1);
    sent_before = m_sent;
    set_in(0,1,1, 1,50,0, 0,0,0, 0); step();
    chk("tp5_flush_req", net_req, 1'b0);
    chk("tp5_flush_busy", busy, 1'b0);
    chk("tp5_flush_ready", res_ready, 1'b1);
    chk("tp5_flush_sent", sent_count, sent_before);
    set_in(0,0,0, 0,0,0, 0,0,0, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("tp5_no_flit_after_flush", net_req, 1'b0);
    end
    set_in(0,0,1, 1,60,1, 0,0,0, 0); step();
    set_in(0,0,0, 0,0,0, 0,0,0, 0);  step();
    sent_before = m_sent;
    set_in(0,1,0, 0,0,0, 0,0,0, 1);  step();
    chk("tp5_flush_beats_ack", sent_count, sent_before);
    chk("tp5_flush_ack_req", net_req, 1'b0);

    // reset in the middle of a stalled transfer
    set_in(0,0,1, 1,70,0, 1,71,2, 0); step();
    set_in(0,0,0, 0,0,0, 0,0,0, 0);   step();
    chk("tp6_setup_req", net_req, 1'b1);
    set_in(1,0,0, 0,0,0, 0,0,0, 1);   step();
    chk("tp6_rst_req", net_req, 1'b0);
    chk("tp6_rst_ready", res_ready, 1'b1);
    chk("tp6_rst_busy", busy, 1'b0);
    chk("tp6_rst_sent", sent_count, 0);
    chk("tp6_rst_stall", stall_count, 0);
    chk("tp6_rst_operand", net_operand, 0);
    chk("tp6_rst_instr", net_dest_instr, 0);
    chk("tp6_rst_slot", net_dest_slot, 0);
    set_in(0,0,1, 1,80,1, 0,0,0, 0); step();
    chk("tp6_accept_req", net_req, 1'b0);
    set_in(0,0,0, 0,0,0, 0,0,0, 0);  step();
    chk("tp6_latency_req", net_req, 1'b1);
    chk("tp6_latency_instr", net_dest_instr, 80);

    // stall counter saturation
    for (int k = 0; k < CMAX + 8; k++) step();
    chk("sat_stall", stall_count, CMAX);
    set_in(0,0,0, 0,0,0, 0,0,0, 1); step(); step();
    chk("sat_stall_hold", stall_count, CMAX);

    // random traffic against the model
    ackp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) ackp = $urandom_range(0, 100);
      res_operand = {1'($urandom_range(0,1)), 7'($urandom), 32'($urandom)};
      set_in(($urandom_range(0, 999) < 3), ($urandom_range(0, 99) < 2),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), IW'($urandom), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), IW'($urandom), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 99) < ackp));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_inject_scheduler.md
Name: operand_inject_scheduler

Overview:
- Per-E-node scheduler sitting between an E-node's result stage and its local injection port on the operand switching network.
- Buffers produced results, each carrying up to 2 targets (N[instr,slot] form). Serialises them into single-flit req/ack transactions on the network's local port, target 0 before target 1.
- Provides result-side backpressure, block-flush abort and performance counters.

Parameters:
FIFO_DEPTH, 4, result-buffer entries (power of 2, >=2)
CNT_W, 16, width of performance counters (saturating)

Ports:
clk  input  1  core clock; all logic on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  block flush/commit-abort; discards all buffered and in-flight work
res_valid  input  1  E-node presents a result
res_ready  output  1  buffer can accept a result this cycle
res_operand  input  operand_t  result operand (data/valid/source_instr)
t0_valid  input  1  target 0 present
t0_instr  input  instr_num_t  target 0 destination instruction
t0_slot  input  2  target 0 slot (0=left,1=right,2=p,3=reserved)
t1_valid  input  1  target 1 present
t1_instr  input  instr_num_t  target 1 destination instruction
t1_slot  input  2  target 1 slot
net_operand  output  operand_t  to network local in_operand
net_dest_instr  output  instr_num_t  to network local in_dest_instr
net_dest_slot  output  2  to network local in_dest_slot
net_req  output  1  to network local in_req
net_ack  input  1  from network local out_ack
busy  output  1  buffer non-empty or net_req high
sent_count  output  CNT_W  flits accepted by network
stall_count  output  CNT_W  cycles with net_req=1 and net_ack=0

Behaviour:
- Reset (rst=1 at an edge): all outputs 0 next cycle, except res_ready=1. FIFO empty, FSM=IDLE, counters 0. Reset mid-transaction abandons the flit; no ack is awaited.
- Target validity: a target is effective iff tN_valid=1 and tN_slot!=3. A slot-3 target is silently dropped.
- Enqueue:
  - res_ready = (occupancy < FIFO_DEPTH), combinational from registered occupancy.
  - Accept when res_valid && res_ready.
  - A result with zero effective targets is accepted but not stored.
  - Otherwise one entry is stored: {operand, effective mask, instr0, slot0, instr1, slot1}.
  - Enqueue and dequeue in the same cycle are legal when full: no overflow, since res_ready already reflects full.
- FSM states: IDLE, SEND0, SEND1.
  - IDLE: if FIFO non-empty, load head into output registers. Go to SEND0 if mask[0], else SEND1. net_req=1 from the next cycle.
  - SEND0: hold net_* stable while net_ack=0. On net_req && net_ack:
    - if mask[1], load target1 fields next cycle and go to SEND1 (net_req stays 1);
    - else pop head, then go to SEND0/SEND1 for the next entry with net_req continuously high if one is available, or IDLE with net_req=0 if not.
  - SEND1: same rules; completion always pops the head.
- Latency: result accepted at edge k into an empty FIFO gives net_req=1 in cycle k+1.
- Throughput: with net_ack tied high, one flit per cycle, no bubbles between targets or between entries.
- Handshake: net_operand, net_dest_instr, net_dest_slot are registered and never change while net_req=1 && net_ack=0. A transfer completes only in a cycle with both high. net_ack while net_req=0 is ignored.
- Flush: at the edge where flush=1, the FIFO is emptied, FSM=IDLE and net_req=0 next cycle, even mid-handshake.
  - A res_valid in the same cycle is discarded; res_ready stays asserted.
  - Counters are not cleared.
  - flush has priority over net_ack in the same cycle: that flit is not counted.
- Counters:
  - sent_count += 1 per completed transfer.
  - stall_count += 1 per cycle with net_req && !net_ack.
  - Both saturate at 2^CNT_W-1.
- busy = (occupancy != 0) || net_req.

Test Plan:
- Two-target result (operand 0x1234, t0=instr 5 slot 0, t1=instr 9 slot 2), net_ack=1 -> cycle k+1 flit {5,0}, k+2 flit {9,2}, net_req=0 at k+3, sent_count=2.
- Same result with net_ack=0 for 3 cycles then 1 -> first flit held stable for 4 cycles, stall_count=3, then second flit; all fields unchanged during the stall.
- 5 single-target results back-to-back with net_ack=0 -> res_ready drops after 4 accepts and the 5th is held. Raise net_ack -> 4 flits on consecutive cycles in FIFO order, 5th accepted when space frees.
- Result with t0_valid=0 and t1 slot=3 -> accepted, no flit, busy stays 0. Result with only t1 valid -> exactly one flit carrying t1 fields.
- Flush asserted while net_req=1, net_ack=0, 2 entries buffered -> next cycle net_req=0, busy=0, sent_count unchanged. A res_valid in the flush cycle produces no flit.
- rst asserted mid-stream (net_req=1) -> next cycle all outputs 0, res_ready=1, counters 0. A fresh result after release gives net_req one cycle after acceptance.
